// File: rtl/fir_filter_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : fir_filter_pkg                                               |
// | Description : Shared types and constants for the fir_filter serial link.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package fir_filter_pkg;

    localparam int DEFAULT_WORD_LEN = 24;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RDY = 2'd1,
        SHIFT    = 2'd2
    } ser_state_t;

endpackage : fir_filter_pkg

`default_nettype wire

// File: rtl/piso_shift_reg.sv
// +----------------------------------------------------------------------------+
// | Module      : piso_shift_reg                                               |
// | Description : Loadable zero-filling shift register with serial tap.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module piso_shift_reg #(
    parameter int LENGTH    = 24,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [LENGTH-1:0] iv_din,
    output logic              o_sout
);

    logic [LENGTH-1:0] r_sr;
    logic [LENGTH-1:0] w_next;

    // The tap always presents the next bit to transmit; shifting exposes the following one.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_next = {r_sr[LENGTH-2:0], 1'b0};
            assign o_sout = r_sr[LENGTH-1];
        end else begin : g_lsb_first
            assign w_next = {1'b0, r_sr[LENGTH-1:1]};
            assign o_sout = r_sr[0];
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= iv_din;
        end else if (i_shift) begin
            r_sr <= w_next;
        end
    end

endmodule : piso_shift_reg

`default_nettype wire

// File: rtl/serializer_fsm.sv
// +----------------------------------------------------------------------------+
// | Module      : serializer_fsm                                               |
// | Description : PISO transmitter, one word per handshake, one bit per clock. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module serializer_fsm
    import fir_filter_pkg::*;
#(
    parameter int LENGTH    = DEFAULT_WORD_LEN,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [LENGTH-1:0] iv_din,
    input  logic              i_din_valid,
    output logic              o_ready,
    input  logic              i_ready,
    output logic              o_dout,
    output logic              o_dout_valid
);

    localparam int               CNT_W      = $clog2(LENGTH);
    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(LENGTH - 1);

    ser_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ready;
    logic             r_dout;
    logic             r_dout_valid;

    logic w_load;
    logic w_shift;
    logic w_sout;

    assign w_load  = i_en && (r_state == IDLE) && r_ready && i_din_valid;
    // The register advances on every bit registered onto o_dout, including the first.
    assign w_shift = i_en && (((r_state == WAIT_RDY) && i_ready) ||
                              ((r_state == SHIFT) && (r_cnt != c_last_bit)));

    piso_shift_reg #(
        .LENGTH    (LENGTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .iv_din  (iv_din),
        .o_sout  (w_sout)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_ready      <= 1'b0;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
        end else if (!i_en) begin
            // Freeze the frame; the pause shows downstream as valid-low cycles.
            r_ready      <= 1'b0;
            r_dout_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_dout_valid <= 1'b0;
                    if (r_ready && i_din_valid) begin
                        r_ready <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= WAIT_RDY;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                WAIT_RDY: begin
                    r_ready      <= 1'b0;
                    r_dout_valid <= 1'b0;
                    if (i_ready) begin
                        r_dout       <= w_sout;
                        r_dout_valid <= 1'b1;
                        r_state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_cnt == c_last_bit) begin
                        r_dout       <= 1'b0;
                        r_dout_valid <= 1'b0;
                        r_ready      <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_cnt        <= r_cnt + CNT_W'(1);
                        r_dout       <= w_sout;
                        r_dout_valid <= 1'b1;
                        r_ready      <= 1'b0;
                    end
                end
                default: begin
                    r_ready      <= 1'b0;
                    r_dout_valid <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign o_ready      = r_ready;
    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;

endmodule : serializer_fsm

`default_nettype wire
